// File: rtl/score_glyph_sched_pkg.sv
// Shared constants for the dino HUD score/glyph scheduler: slot geometry,
// glyph indices and FSM encodings.
package score_glyph_sched_pkg;

    localparam int TOP        = 80;
    localparam int X_LABEL    = 218;
    localparam int X_HI       = 236;
    localparam int X_CUR      = 272;
    localparam int PIC_WIDTH  = 6;
    localparam int PIC_HEIGHT = 9;
    localparam int GLYPH_SIZE = 54;
    localparam int ROM_LAT    = 1;
    localparam int NUM_SLOTS  = 12;

    localparam logic [3:0] GLYPH_H = 4'd10;
    localparam logic [3:0] GLYPH_I = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Slots 0-1: "H","I"; 2-6: high-score digits MSD first; 7-11: current score.
    function automatic int slot_x(input int s);
        if (s < 2)
            return X_LABEL + PIC_WIDTH * s;
        else if (s < 7)
            return X_HI + PIC_WIDTH * (s - 2);
        else
            return X_CUR + PIC_WIDTH * (s - 7);
    endfunction

endpackage

// File: rtl/score_glyph_sched_bcd_counter5.sv
// Five-digit BCD up-counter with clear, saturation at 99999 and a
// magnitude compare against another BCD value.
module bcd_counter5
    import score_glyph_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        inc,
    input  logic [19:0] other,
    output logic [19:0] value,
    output logic        gt
);

    logic [19:0] value_next;
    logic        carry;

    always_comb begin
        value_next = value;
        carry      = 1'b1;
        for (int d = 0; d < 5; d++) begin
            if (carry) begin
                if (value[4*d +: 4] == 4'd9) begin
                    value_next[4*d +: 4] = 4'd0;
                end else begin
                    value_next[4*d +: 4] = value[4*d +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
    end

    // Valid BCD orders the same way as plain binary, so a direct compare works.
    assign gt = (value > other);

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc && value != 20'h99999)
            value <= value_next;
    end

endmodule

// File: rtl/score_glyph_sched.sv
// Dino-game score FSM plus per-pixel scheduling of the shared 12-glyph ROM
// across the HUD label, high-score and current-score slots.
module score_glyph_sched
    import score_glyph_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        game_start,
    input  logic        game_tick,
    input  logic        game_over,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    output logic [9:0]  rom_addr,
    output logic        rom_en,
    output logic        pix_valid,
    output logic [19:0] score,
    output logic [19:0] hi_score,
    output logic        running
);

    state_t state;
    logic   score_clr;
    logic   score_inc;
    logic   score_gt;

    assign score_clr = (state != ST_RUN) && game_start;
    assign score_inc = (state == ST_RUN) && game_tick && !game_over;

    bcd_counter5 u_score (
        .clk   (clk),
        .rst   (rst),
        .clr   (score_clr),
        .inc   (score_inc),
        .other (hi_score),
        .value (score),
        .gt    (score_gt)
    );

    // The compare sees the pre-tick score, so a same-cycle tick never reaches hi_score.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            hi_score <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (game_start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (game_over) begin
                        state   <= ST_OVER;
                        running <= 1'b0;
                        if (score_gt)
                            hi_score <= score;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    int          h_addr;
    int          v_addr;
    int          addr_int;
    logic        in_row;
    logic        hit;
    logic        visible;
    logic [3:0]  glyph;
    logic        unused_lsb;

    assign unused_lsb = h_cnt[0] ^ v_cnt[0];

    always_comb begin
        h_addr   = int'(h_cnt[9:1]);
        v_addr   = int'(v_cnt[9:1]);
        in_row   = (v_addr >= TOP) && (v_addr < TOP + PIC_HEIGHT);
        hit      = 1'b0;
        addr_int = 0;
        glyph    = 4'd0;
        visible  = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (s == 0)
                glyph = GLYPH_H;
            else if (s == 1)
                glyph = GLYPH_I;
            else if (s < 7)
                glyph = hi_score[4*(6-s) +: 4];
            else
                glyph = score[4*(11-s) +: 4];
            visible = (s >= 7) || (hi_score != 20'h0);
            if (visible && in_row && h_addr >= slot_x(s) && h_addr < slot_x(s) + PIC_WIDTH) begin
                hit      = 1'b1;
                addr_int = int'(glyph) * GLYPH_SIZE + (v_addr - TOP) * PIC_WIDTH
                           + (h_addr - slot_x(s));
            end
        end
    end

    logic [ROM_LAT-1:0] en_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            rom_en   <= 1'b0;
            en_pipe  <= '0;
        end else begin
            rom_addr   <= hit ? 10'(addr_int) : 10'd0;
            rom_en     <= hit;
            en_pipe[0] <= rom_en;
            for (int i = 1; i < ROM_LAT; i++)
                en_pipe[i] <= en_pipe[i-1];
        end
    end

    assign pix_valid = en_pipe[ROM_LAT-1];

endmodule

// File: doc/score_glyph_sched.md
Name: score_glyph_sched

Overview:
- Owns the dino-game score state: a 5-digit BCD current score, a 5-digit BCD high score, and the run/over sequencing between them.
- Schedules a single shared 12-glyph ROM across the 12 HUD slots:
  - "H" and "I" label,
  - 5 high-score digits,
  - 5 current-score digits.
- For each VGA pixel it produces the ROM address plus a valid flag aligned with the ROM output.
- Sits between the VGA timing generator and the HUD pixel mux.

Parameters:
TOP, 80, top row of all glyphs (half-res coordinates)
X_LABEL, 218, x of "H"; "I" at X_LABEL+6
X_HI, 236, x of high-score MSD; digits at pitch PIC_WIDTH
X_CUR, 272, x of current-score MSD; digits at pitch PIC_WIDTH
PIC_WIDTH, 6, glyph width in pixels
PIC_HEIGHT, 9, glyph height in pixels
ROM_LAT, 1, glyph ROM read latency in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
game_start  in  1  one-cycle pulse: begin a run
game_tick  in  1  one-cycle pulse: add 1 to score
game_over  in  1  one-cycle pulse: end a run
h_cnt  in  10  VGA horizontal count (full res)
v_cnt  in  10  VGA vertical count (full res)
rom_addr  out  10  shared glyph ROM address
rom_en  out  1  ROM read enable (pixel lies inside a visible slot)
pix_valid  out  1  ROM data valid for current pixel, delayed by ROM_LAT
score  out  20  current score, 5 BCD digits, MSD in [19:16]
hi_score  out  20  high score, 5 BCD digits
running  out  1  high while in RUN

Behaviour:
- Reset values:
  - state IDLE;
  - score, hi_score = 0;
  - rom_addr, rom_en, pix_valid, running = 0.
- FSM IDLE/RUN/OVER, all transitions on the clk edge:
  - IDLE --game_start--> RUN, score cleared.
  - RUN --game_over--> OVER; in the same edge hi_score <= score if score > hi_score (compare the pre-tick score value).
  - OVER --game_start--> RUN, score cleared; hi_score kept.
  - game_start while in RUN: ignored.
  - game_over outside RUN: ignored.
- Score counter:
  - In RUN, game_tick increments BCD with per-digit carry (9 -> 0, carry to next digit).
  - Saturates at 99999; further ticks leave it unchanged.
  - Ticks outside RUN are ignored.
  - game_tick and game_over in the same cycle: game_over wins and the tick is dropped.
- Coordinates: h_addr = h_cnt>>1, v_addr = v_cnt>>1.
  - A pixel is in the glyph row when TOP <= v_addr < TOP+PIC_HEIGHT.
  - Slot s spans [x_s, x_s+PIC_WIDTH).
- Glyph index mapping:
  - 0..9 = digit value, 10 = "H", 11 = "I".
  - Digit slots take their value from the live score / hi_score registers.
  - Leading zeros are displayed.
- Visibility:
  - Label and high-score slots are visible only when hi_score != 0.
  - Current-score slots are always visible (IDLE shows 00000).
- Address: glyph*54 + (v_addr-TOP)*6 + (h_addr-x_s), range 0..647.
- Pipeline:
  - Stage 1: the decode is registered into rom_addr and rom_en, one clk after h_cnt/v_cnt.
  - pix_valid is rom_en delayed ROM_LAT cycles, so it is aligned with the ROM dout.
  - Outside every visible slot: rom_en = 0 and rom_addr = 0.
- Score changes take effect from the next decoded pixel; a mid-frame glyph change is allowed.
- rst asserted mid-run returns everything to the reset values on the next edge, including hi_score.

Decomposition:
- Shared package holds:
  - the slot x-positions,
  - TOP, PIC_WIDTH, PIC_HEIGHT, GLYPH_SIZE = 54,
  - glyph index constants GLYPH_H = 10, GLYPH_I = 11,
  - FSM state encodings.
- One natural sub-module, bcd_counter5:
  - 5-digit BCD increment with saturation and clear;
  - exposes a greater-than compare used for the high-score update.

Test Plan:
- Reset, game_start, 3 game_tick -> score = 20'h00003, running = 1, hi_score = 0.
- Score 20'h00999 + tick -> 20'h01000. Score 20'h99999 + tick -> unchanged 20'h99999.
- Score 123, game_over -> OVER, hi_score = 20'h00123. Then game_start, 50 ticks, game_over -> hi_score stays 20'h00123.
- game_tick and game_over in the same cycle at score 7 -> score stays 7, hi_score = 7.
- Address and visibility checks:
  - Score 0, hi 0, pixel (h_addr 274, v_addr 83) -> next clk rom_addr = 20, rom_en = 1; pix_valid = 1 one clk later.
  - Pixel at h_addr 236 -> rom_en = 0 because hi = 0.
  - With hi 5, pixel at h_addr 218, v_addr 80 -> rom_addr = 540.
- rst pulse mid-RUN at score 42 -> next clk: score = 0, hi_score = 0, state IDLE, rom_en = 0.
